// File: rtl/rle_line_encoder.sv
// Binary mask to run-length encoder: one pixel per accepted cycle, up to two
// run words per cycle into a first-word-fall-through FIFO with valid/ready output.
module rle_line_encoder #(
   parameter int IMG_W      = 640,
   parameter int LEN_W      = 11,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             in_sop,
   output logic [LEN_W-1:0] run_len,
   output logic             run_sym,
   output logic             run_last,
   output logic             run_valid,
   input  logic             run_ready,
   output logic             overflow
);

   localparam int               AW      = $clog2(FIFO_DEPTH);
   localparam int               WW      = LEN_W + 2;
   localparam logic [LEN_W-1:0] X_LAST  = LEN_W'(IMG_W - 1);
   localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);

   // Run / position state
   logic [LEN_W-1:0] r_x;
   logic [LEN_W-1:0] r_cur_len;
   logic             r_cur_sym;
   logic             r_overflow;

   // FIFO storage, word layout {len, sym, last}
   logic [WW-1:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic [LEN_W-1:0] w_x_eff;
   logic [LEN_W-1:0] w_x_nxt;
   logic [LEN_W-1:0] w_len_nxt;
   logic [LEN_W-1:0] w_run_len;
   logic             w_sym_nxt;
   logic             w_toggle;
   logic [1:0]       w_npush;
   logic [WW-1:0]    w_word0;
   logic [WW-1:0]    w_word1;
   logic [AW:0]      w_free;
   logic [AW:0]      w_push_n;
   logic             w_drop;
   logic             w_pop;

   always_comb begin
      w_x_eff   = in_sop ? '0 : r_x;
      w_x_nxt   = r_x;
      w_len_nxt = r_cur_len;
      w_sym_nxt = r_cur_sym;
      w_npush   = 2'd0;
      w_word0   = '0;
      w_word1   = '0;
      w_toggle  = (in_bit != r_cur_sym);
      w_run_len = w_toggle ? LEN_W'(1) : r_cur_len + LEN_W'(1);
      if (in_valid) begin
         w_x_nxt = (w_x_eff == X_LAST) ? '0 : w_x_eff + LEN_W'(1);
         if (w_x_eff == '0) begin
            // A line starting with 1 gets a zero-length symbol-0 run first
            w_sym_nxt = in_bit;
            w_len_nxt = LEN_W'(1);
            if (in_bit) begin
               w_npush = 2'd1;
               w_word0 = '0;
            end
         end else begin
            if (w_toggle) begin
               w_word0 = {r_cur_len, r_cur_sym, 1'b0};
               w_npush = 2'd1;
            end
            if (w_x_eff == X_LAST) begin
               // Closing run goes behind the toggled-out run when both occur
               if (w_toggle) begin
                  w_word1 = {w_run_len, in_bit, 1'b1};
                  w_npush = 2'd2;
               end else begin
                  w_word0 = {w_run_len, in_bit, 1'b1};
                  w_npush = 2'd1;
               end
               w_len_nxt = '0;
               w_sym_nxt = 1'b0;
            end else begin
               w_len_nxt = w_run_len;
               w_sym_nxt = in_bit;
            end
         end
      end
   end

   // Space is judged on occupancy before this cycle's pop; a short FIFO drops every push
   always_comb begin
      w_free   = DEPTH_C - r_count;
      w_drop   = ((AW+1)'(w_npush) > w_free);
      w_push_n = w_drop ? '0 : (AW+1)'(w_npush);
      w_pop    = run_valid && run_ready;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_x       <= '0;
         r_cur_len <= '0;
         r_cur_sym <= 1'b0;
      end else begin
         r_x       <= w_x_nxt;
         r_cur_len <= w_len_nxt;
         r_cur_sym <= w_sym_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (in_valid && in_sop) begin
         r_overflow <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!w_drop && (w_npush != 2'd0)) begin
         r_mem[r_wr_ptr] <= w_word0;
      end
      if (!w_drop && (w_npush == 2'd2)) begin
         r_mem[r_wr_ptr + AW'(1)] <= w_word1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + w_push_n[AW-1:0];
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_count  <= r_count + w_push_n - (AW+1)'(w_pop);
      end
   end

   assign run_valid = (r_count != '0);
   assign {run_len, run_sym, run_last} = run_valid ? r_mem[r_rd_ptr] : '0;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_rle_line_encoder.sv
// Bench for rle_line_encoder: table vectors, corner-case sequences and a
// randomized run with a line-level run-length reference model.
module tb_rle_line_encoder;

   localparam int W  = 8;
   localparam int LW = 4;
   localparam int D  = 4;
   localparam int WW = LW + 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_bit = 1'b0;
   logic          in_sop = 1'b0;
   logic          run_ready = 1'b0;
   logic [LW-1:0] run_len;
   logic          run_sym;
   logic          run_last;
   logic          run_valid;
   logic          overflow;

   rle_line_encoder #(.IMG_W(W), .LEN_W(LW), .FIFO_DEPTH(D)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_bit(in_bit), .in_sop(in_sop),
      .run_len(run_len), .run_sym(run_sym), .run_last(run_last),
      .run_valid(run_valid), .run_ready(run_ready), .overflow(overflow)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   int popped = 0;
   logic [WW-1:0] mon_q[$];

   // Handshake seen mid-cycle is the word the next rising edge consumes
   always @(negedge CLK) begin
      if (!RST && run_valid && run_ready) begin
         mon_q.push_back({run_len, run_sym, run_last});
         popped++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [WW-1:0] mk(input int len, input logic sym, input logic last);
      mk = {LW'(len), sym, last};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pix(input logic b, input logic s);
      in_valid = 1'b1;
      in_bit   = b;
      in_sop   = s;
      tick();
      in_valid = 1'b0;
      in_sop   = 1'b0;
   endtask

   task automatic send_line(input logic [W-1:0] p, input logic sop);
      for (int x = 0; x < W; x++) pix(p[W-1-x], sop && (x == 0));
   endtask

   task automatic drain(input int n);
      run_ready = 1'b1;
      repeat (n) tick();
   endtask

   typedef struct {
      logic [W-1:0]  pix;
      int            n;
      logic [WW-1:0] w [3];
   } vec_t;

   vec_t tab [3];

   // Random-phase reference state
   logic [WW-1:0] exp_q[$];
   logic          b [W];
   logic [WW-1:0] e_w [W+1];
   int            e_idx [W+1];
   int            e_n;

   initial begin
      int pushed, pop_base, s, len, guard, sum;
      logic sent, last;

      tab[0].pix = 8'b00011100; tab[0].n = 3;
      tab[0].w[0] = mk(3,0,0); tab[0].w[1] = mk(3,1,0); tab[0].w[2] = mk(2,0,1);
      tab[1].pix = 8'b11111111; tab[1].n = 2;
      tab[1].w[0] = mk(0,0,0); tab[1].w[1] = mk(8,1,1); tab[1].w[2] = '0;
      tab[2].pix = 8'b00000001; tab[2].n = 2;
      tab[2].w[0] = mk(7,0,0); tab[2].w[1] = mk(1,1,1); tab[2].w[2] = '0;

      // Reset state
      repeat (3) tick();
      check("reset run_valid", run_valid, 0);
      check("reset run_len", run_len, 0);
      check("reset run_sym", run_sym, 0);
      check("reset run_last", run_last, 0);
      check("reset overflow", overflow, 0);
      RST = 1'b0;
      tick();

      // Table-driven lines with the consumer always ready
      for (int i = 0; i < 3; i++) begin
         mon_q.delete();
         run_ready = 1'b1;
         send_line(tab[i].pix, 1'b1);
         drain(4);
         check($sformatf("tab%0d word count", i), mon_q.size(), tab[i].n);
         for (int k = 0; k < tab[i].n; k++)
            if (k < mon_q.size()) check($sformatf("tab%0d word%0d", i, k), mon_q[k], tab[i].w[k]);
         check($sformatf("tab%0d overflow", i), overflow, 0);
      end

      // Toggle on the last pixel: two words land in the same cycle
      mon_q.delete();
      run_ready = 1'b0;
      pix(1'b0, 1'b1);
      for (int x = 1; x < W-1; x++) pix(1'b0, 1'b0);
      check("dual push none before last", run_valid, 0);
      pix(1'b1, 1'b0);
      check("dual push valid", run_valid, 1);
      check("dual push head0", {run_len, run_sym, run_last}, mk(7,0,0));
      run_ready = 1'b1;
      tick();
      check("dual push second valid", run_valid, 1);
      check("dual push head1", {run_len, run_sym, run_last}, mk(1,1,1));
      tick();
      check("dual push empty", run_valid, 0);

      // Overflow with a stalled consumer
      mon_q.delete();
      run_ready = 1'b0;
      send_line(8'b01010101, 1'b1);
      check("ovf set", overflow, 1);
      drain(8);
      check("ovf kept count", mon_q.size(), 4);
      for (int k = 0; k < 4 && k < mon_q.size(); k++)
         check($sformatf("ovf kept word%0d", k), mon_q[k], mk(1, k[0], 0));
      check("ovf sticky", overflow, 1);
      mon_q.delete();
      pix(1'b0, 1'b1);
      check("ovf cleared by sop", overflow, 0);
      for (int x = 1; x < W; x++) pix(1'b0, 1'b0);
      drain(4);
      check("after ovf line count", mon_q.size(), 1);
      if (mon_q.size() > 0) check("after ovf line word", mon_q[0], mk(8,0,1));

      // Mid-line sop discards the partial run
      mon_q.delete();
      run_ready = 1'b1;
      pix(1'b0, 1'b1); pix(1'b0, 1'b0); pix(1'b1, 1'b0); pix(1'b1, 1'b0); pix(1'b1, 1'b0);
      send_line(8'b00011100, 1'b1);
      drain(4);
      check("midsop count", mon_q.size(), 4);
      if (mon_q.size() == 4) begin
         check("midsop w0", mon_q[0], mk(2,0,0));
         check("midsop w1", mon_q[1], mk(3,0,0));
         check("midsop w2", mon_q[2], mk(3,1,0));
         check("midsop w3", mon_q[3], mk(2,0,1));
         sum = int'(mon_q[1][WW-1:2]) + int'(mon_q[2][WW-1:2]) + int'(mon_q[3][WW-1:2]);
         check("midsop line sum", sum, W);
      end

      // Reset mid-line with three words buffered
      mon_q.delete();
      run_ready = 1'b0;
      pix(1'b0, 1'b1); pix(1'b1, 1'b0); pix(1'b0, 1'b0); pix(1'b1, 1'b0);
      check("pre-reset valid", run_valid, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("mid reset valid", run_valid, 0);
      check("mid reset overflow", overflow, 0);
      check("mid reset run_len", run_len, 0);
      pix(1'b1, 1'b0);
      check("post reset x0 valid", run_valid, 1);
      check("post reset x0 word", {run_len, run_sym, run_last}, mk(0,0,0));
      for (int x = 1; x < W; x++) pix(1'b1, 1'b0);
      drain(4);
      check("post reset count", mon_q.size(), 2);
      if (mon_q.size() == 2) check("post reset closing", mon_q[1], mk(8,1,1));

      // Randomized lines, gaps and back-pressure against the line-level model
      mon_q.delete();
      exp_q.delete();
      pushed   = 0;
      pop_base = popped;
      for (int line = 0; line < 40; line++) begin
         for (int x = 0; x < W; x++) b[x] = 1'($urandom_range(0, 1));
         e_n = 0;
         if (b[0]) begin e_w[e_n] = mk(0,0,0); e_idx[e_n] = 0; e_n++; end
         s = 0;
         while (s < W) begin
            len = 1;
            while (s + len < W && b[s+len] == b[s]) len++;
            last = (s + len == W);
            e_w[e_n] = mk(len, b[s], last);
            e_idx[e_n] = last ? W-1 : s + len;
            e_n++;
            s += len;
         end
         for (int x = 0; x < W; x++) begin
            sent  = 1'b0;
            guard = 0;
            while (!sent && guard < 200) begin
               guard++;
               run_ready = ($urandom_range(0, 2) != 0);
               if ($urandom_range(0, 3) != 0 && (pushed - (popped - pop_base)) + 2 <= D) begin
                  in_valid = 1'b1;
                  in_bit   = b[x];
                  in_sop   = (x == 0) && (line == 0 || $urandom_range(0, 1) == 1);
                  sent     = 1'b1;
               end else begin
                  in_valid = 1'b0;
                  in_bit   = 1'($urandom_range(0, 1));
                  in_sop   = 1'($urandom_range(0, 1));
               end
               tick();
            end
            in_valid = 1'b0;
            in_sop   = 1'b0;
            if (!sent) check("random pixel accepted", 0, 1);
            for (int k = 0; k < e_n; k++)
               if (e_idx[k] == x) begin exp_q.push_back(e_w[k]); pushed++; end
         end
      end
      drain(12);
      check("random word count", mon_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++)
         check($sformatf("random word%0d", k), mon_q[k], exp_q[k]);
      check("random overflow", overflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
